// File: rtl/key_debouncer_pkg.sv
// Shared defaults and width helper for the key debouncer slice.
package key_debouncer_pkg;

    localparam int unsigned DEF_W          = 4;
    localparam int unsigned DEF_STABLE_CNT = 4;

    // Counter width able to hold 0..stable_cnt-1 with one spare bit
    function automatic int unsigned cnt_width(input int unsigned stable_cnt);
        return 32'($clog2(stable_cnt) + 1);
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// Single key channel: two-flop synchroniser, strobe-counted stability filter,
// registered press/release pulses and a press-toggled level.
module key_debounce_bit
    import key_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic key_raw,
    output logic key_level,
    output logic key_pressed,
    output logic key_released,
    output logic key_toggle
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             s0;
    logic             s1;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             pressed_nxt;
    logic             released_nxt;
    logic             toggle_nxt;

    // Synchroniser runs every clock, independent of the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= key_raw;
            s1 <= s0;
        end
    end

    // Filter: count strobed mismatches, accept the new level on the last one
    always_comb begin
        cnt_nxt      = cnt;
        level_nxt    = key_level;
        pressed_nxt  = 1'b0;
        released_nxt = 1'b0;
        toggle_nxt   = key_toggle;
        if (s1 == key_level) begin
            cnt_nxt = '0;
        end else if (sample_en) begin
            if (cnt >= CNT_LAST) begin
                cnt_nxt      = '0;
                level_nxt    = s1;
                pressed_nxt  = s1;
                released_nxt = ~s1;
                toggle_nxt   = key_toggle ^ s1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Filter state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            key_level    <= 1'b0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
            key_toggle   <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            key_level    <= level_nxt;
            key_pressed  <= pressed_nxt;
            key_released <= released_nxt;
            key_toggle   <= toggle_nxt;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Debounces W push-button inputs; one independent channel per key.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned W          = DEF_W,
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic [W-1:0] key_raw,
    output logic [W-1:0] key_level,
    output logic [W-1:0] key_pressed,
    output logic [W-1:0] key_released,
    output logic [W-1:0] key_toggle
);

    // One channel per key bit; channels share only clock, reset and strobe
    for (genvar i = 0; i < int'(W); i++) begin : g_key
        key_debounce_bit #(
            .STABLE_CNT (STABLE_CNT)
        ) u_bit (
            .clk          (clk),
            .rst_n        (rst_n),
            .sample_en    (sample_en),
            .key_raw      (key_raw[i]),
            .key_level    (key_level[i]),
            .key_pressed  (key_pressed[i]),
            .key_released (key_released[i]),
            .key_toggle   (key_toggle[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer with a behavioural per-key model.
module tb_key_debouncer;

    localparam int unsigned W  = 4;
    localparam int unsigned SC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sample_en = 1'b0;
    logic [W-1:0] key_raw = '0;
    logic [W-1:0] key_level;
    logic [W-1:0] key_pressed;
    logic [W-1:0] key_released;
    logic [W-1:0] key_toggle;

    int vectors = 0;
    int miscompares = 0;

    key_debouncer #(.W(W), .STABLE_CNT(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .key_raw      (key_raw),
        .key_level    (key_level),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .key_toggle   (key_toggle)
    );

    always #5 clk = ~clk;

    // Reference model: raw is seen two clocks late; a new level is accepted once
    // it has been observed continuously across SC strobes.
    logic [W-1:0] m_d1 = '0, m_d2 = '0;
    logic [W-1:0] m_level = '0, m_pressed = '0, m_released = '0, m_toggle = '0;
    int           m_strobes [W];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_pressed = '0; m_released = '0; m_toggle = '0;
            for (int i = 0; i < int'(W); i++) m_strobes[i] = 0;
        end else begin
            m_pressed  = '0;
            m_released = '0;
            for (int i = 0; i < int'(W); i++) begin
                if (m_d2[i] == m_level[i]) begin
                    m_strobes[i] = 0;
                end else if (sample_en) begin
                    m_strobes[i] = m_strobes[i] + 1;
                    if (m_strobes[i] == int'(SC)) begin
                        m_level[i]    = m_d2[i];
                        m_pressed[i]  = m_d2[i];
                        m_released[i] = !m_d2[i];
                        if (m_d2[i]) m_toggle[i] = !m_toggle[i];
                        m_strobes[i]  = 0;
                    end
                end
            end
            m_d2 = m_d1;
            m_d1 = key_raw;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        key_raw = 4'hF;
        sample_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if ({key_level, key_pressed, key_released, key_toggle} !== 16'h0) begin
                miscompares++;
                $display("FAIL reset c=%0d got lvl/prs/rel/tgl=%h/%h/%h/%h want 0", c,
                         key_level, key_pressed, key_released, key_toggle);
            end
        end
        key_raw = '0;
        sample_en = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_press();
        int pulses = 0;
        key_raw[0] = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            sample_en = (c % 8 == 0);
            tick();
            pulses += int'(key_pressed[0]);
            vectors++;
            if ({key_level, key_pressed, key_released, key_toggle} !==
                {m_level, m_pressed, m_released, m_toggle}) begin
                miscompares++;
                $display("FAIL press c=%0d got %h/%h/%h/%h want %h/%h/%h/%h", c, key_level,
                         key_pressed, key_released, key_toggle, m_level, m_pressed, m_released, m_toggle);
            end
        end
        sample_en = 1'b0;
        vectors++;
        if (pulses != 1 || key_level[0] !== 1'b1 || key_toggle[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL press_summary got pulses=%0d lvl=%b tgl=%b want 1/1/1",
                     pulses, key_level[0], key_toggle[0]);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            key_raw[1] = (c <= 12);
            sample_en  = (c % 4 == 0);
            tick();
            pulses += int'(key_pressed[1]) + int'(key_released[1]);
            vectors++;
            if ({key_level, key_pressed, key_released, key_toggle} !==
                {m_level, m_pressed, m_released, m_toggle}) begin
                miscompares++;
                $display("FAIL glitch c=%0d got %h/%h/%h/%h want %h/%h/%h/%h", c, key_level,
                         key_pressed, key_released, key_toggle, m_level, m_pressed, m_released, m_toggle);
            end
        end
        sample_en = 1'b0;
        vectors++;
        if (pulses != 0 || key_level[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_summary got pulses=%0d lvl=%b want 0/0", pulses, key_level[1]);
        end
    endtask

    task automatic test_release_toggle();
        logic [2:0] phase_raw = 3'b101;
        logic [2:0] want_tgl  = 3'b011;
        sample_en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            int prs = 0;
            int rel = 0;
            key_raw[2] = phase_raw[p];
            for (int c = 0; c < 12; c++) begin
                tick();
                prs += int'(key_pressed[2]);
                rel += int'(key_released[2]);
                vectors++;
                if ((key_pressed & key_released) !== '0) begin
                    miscompares++;
                    $display("FAIL rel_tgl_overlap got prs=%h rel=%h want disjoint", key_pressed, key_released);
                end
            end
            vectors++;
            if (prs != int'(phase_raw[p]) || rel != int'(!phase_raw[p]) ||
                key_toggle[2] !== want_tgl[p] || key_level[2] !== phase_raw[p]) begin
                miscompares++;
                $display("FAIL rel_tgl phase=%0d got prs=%0d rel=%0d tgl=%b lvl=%b want %0d/%0d/%b/%b",
                         p, prs, rel, key_toggle[2], key_level[2], int'(phase_raw[p]),
                         int'(!phase_raw[p]), want_tgl[p], phase_raw[p]);
            end
        end
        sample_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        rst_n = 1'b0;
        key_raw = '0;
        tick();
        rst_n = 1'b1;
        tick();
        sample_en = 1'b1;
        key_raw = 4'b1010;
        for (int c = 1; c <= 9; c++) begin
            tick();
            vectors++;
            if (key_pressed !== ((c == 6) ? 4'b1010 : 4'b0000)) begin
                miscompares++;
                $display("FAIL simultaneous c=%0d got prs=%b want %b", c, key_pressed,
                         (c == 6) ? 4'b1010 : 4'b0000);
            end
        end
        sample_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        key_raw = '0;
        tick();
        rst_n = 1'b1;
        tick();
        sample_en = 1'b1;
        key_raw[3] = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({key_level, key_pressed, key_released, key_toggle} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid got %h/%h/%h/%h want 0", key_level, key_pressed, key_released, key_toggle);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            vectors++;
            if (key_pressed[3] !== (c == 6) || key_level[3] !== (c >= 6)) begin
                miscompares++;
                $display("FAIL reset_mid_press c=%0d got prs=%b lvl=%b want %b/%b", c,
                         key_pressed[3], key_level[3], c == 6, c >= 6);
            end
        end
        sample_en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(W); i++)
                if ($urandom_range(15) == 0) key_raw[i] = !key_raw[i];
            sample_en = ($urandom_range(2) == 0);
            tick();
            vectors++;
            if ({key_level, key_pressed, key_released, key_toggle} !==
                {m_level, m_pressed, m_released, m_toggle} || (key_pressed & key_released) !== '0) begin
                miscompares++;
                $display("FAIL random c=%0d got %h/%h/%h/%h want %h/%h/%h/%h", c, key_level,
                         key_pressed, key_released, key_toggle, m_level, m_pressed, m_released, m_toggle);
            end
        end
        sample_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_release_toggle();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
